// File: rtl/bcd_counter_scan_nled.sv
// N-digit BCD up/down counter with load, wrap pulse and multiplexed
// common-anode scan drive (optional leading-zero blanking).
module bcd_counter_scan_nled #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned SEL_W      = 2,
  parameter int unsigned TICK_DIV   = 50,
  parameter int unsigned SCAN_DIV   = 50,
  parameter int unsigned LZ_BLANK   = 0
) (
  input  logic                    clk_in,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    up_dn,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_val,
  input  logic [SEL_W-1:0]        sel_an,
  output logic [3:0]              num,
  output logic [NUM_DIGITS-1:0]   an_scan,
  output logic [4*NUM_DIGITS-1:0] bcd_all,
  output logic                    wrap
);

  localparam int unsigned DW     = 4 * NUM_DIGITS;
  localparam int unsigned TICK_W = $clog2(TICK_DIV + 1);
  localparam int unsigned SCAN_W = $clog2(SCAN_DIV + 1);

  logic [DW-1:0]     r_bcd;
  logic [TICK_W-1:0] r_tick_cnt;
  logic [SCAN_W-1:0] r_scan_cnt;
  logic [SEL_W-1:0]  r_idx;
  logic              r_wrap;

  logic              w_tick;
  logic              w_scan_end;
  logic [DW-1:0]     w_bcd_nxt;
  logic              w_wrap_nxt;
  logic              w_cy;
  logic [3:0]        w_dig;
  logic [3:0]        w_nib;
  logic              w_upper_zero;

  assign w_tick     = en && (r_tick_cnt == TICK_W'(TICK_DIV));
  assign w_scan_end = (r_scan_cnt == SCAN_W'(SCAN_DIV));

  // Next counter value: load sanitises nibbles, tick ripples carry/borrow
  // through active digits; inactive digits are always cleared.
  always_comb begin
    w_bcd_nxt  = '0;
    w_wrap_nxt = 1'b0;
    w_cy       = 1'b1;
    w_dig      = 4'd0;
    w_nib      = 4'd0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      w_dig = r_bcd[4*k +: 4];
      w_nib = load_val[4*k +: 4];
      if (SEL_W'(k) <= sel_an) begin
        if (load) begin
          w_bcd_nxt[4*k +: 4] = (w_nib <= 4'd9) ? w_nib : 4'd0;
        end else if (w_tick && w_cy) begin
          if (up_dn) begin
            if (w_dig == 4'd9) begin
              w_bcd_nxt[4*k +: 4] = 4'd0;
            end else begin
              w_bcd_nxt[4*k +: 4] = w_dig + 4'd1;
              w_cy                = 1'b0;
            end
          end else begin
            if (w_dig == 4'd0) begin
              w_bcd_nxt[4*k +: 4] = 4'd9;
            end else begin
              w_bcd_nxt[4*k +: 4] = w_dig - 4'd1;
              w_cy                = 1'b0;
            end
          end
        end else begin
          w_bcd_nxt[4*k +: 4] = w_dig;
        end
      end
    end
    w_wrap_nxt = !load && w_tick && w_cy;
  end

  // Counter value, wrap pulse and tick prescaler.
  always_ff @(posedge clk_in) begin
    if (!rst) begin
      r_bcd      <= '0;
      r_wrap     <= 1'b0;
      r_tick_cnt <= TICK_W'(1);
    end else begin
      r_bcd  <= w_bcd_nxt;
      r_wrap <= w_wrap_nxt;
      if (load) begin
        r_tick_cnt <= TICK_W'(1);
      end else if (en) begin
        r_tick_cnt <= w_tick ? TICK_W'(1) : r_tick_cnt + TICK_W'(1);
      end
    end
  end

  // Free-running scan timer and digit index; index snaps to 0 if out of range.
  always_ff @(posedge clk_in) begin
    if (!rst) begin
      r_scan_cnt <= SCAN_W'(1);
      r_idx      <= '0;
    end else begin
      r_scan_cnt <= w_scan_end ? SCAN_W'(1) : r_scan_cnt + SCAN_W'(1);
      if (r_idx > sel_an) begin
        r_idx <= '0;
      end else if (w_scan_end) begin
        r_idx <= (r_idx >= sel_an) ? '0 : r_idx + SEL_W'(1);
      end
    end
  end

  // Scan outputs decoded from registered state.
  always_comb begin
    num          = r_bcd[{r_idx, 2'b00} +: 4];
    w_upper_zero = 1'b1;
    an_scan      = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if ((SEL_W'(k) >= r_idx) && (SEL_W'(k) <= sel_an) && (r_bcd[4*k +: 4] != 4'd0)) begin
        w_upper_zero = 1'b0;
      end
      if (SEL_W'(k) == r_idx) begin
        an_scan[k] = 1'b0;
      end
    end
    if ((LZ_BLANK != 0) && (r_idx != '0) && w_upper_zero) begin
      an_scan = '1;
    end
  end

  assign bcd_all = r_bcd;
  assign wrap    = r_wrap;

endmodule

// File: tb/tb_bcd_counter_scan_nled.sv
// Randomised self-checking bench for bcd_counter_scan_nled against a
// decimal-arithmetic reference model (two instances: plain and LZ blanking).
module tb_bcd_counter_scan_nled;

  localparam int ND       = 4;
  localparam int TICK_DIV = 2;
  localparam int SCAN_DIV = 1;

  logic          clk_in = 1'b0;
  logic          rst = 1'b0, en = 1'b0, up_dn = 1'b1, load = 1'b0;
  logic [15:0]   load_val = '0;
  logic [1:0]    sel_an = 2'd3;
  logic [3:0]    num, num1;
  logic [3:0]    an_scan, an_scan1;
  logic [15:0]   bcd_all, bcd_all1;
  logic          wrap, wrap1;

  int checks = 0;
  int errors = 0;

  // reference model state
  int m_val = 0, m_tc = 1, m_sc = 1, m_idx = 0;
  bit m_wrap = 1'b0;

  bcd_counter_scan_nled #(.NUM_DIGITS(ND), .SEL_W(2), .TICK_DIV(TICK_DIV),
                          .SCAN_DIV(SCAN_DIV), .LZ_BLANK(0)) dut (
    .clk_in(clk_in), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .sel_an(sel_an), .num(num), .an_scan(an_scan),
    .bcd_all(bcd_all), .wrap(wrap));

  bcd_counter_scan_nled #(.NUM_DIGITS(ND), .SEL_W(2), .TICK_DIV(TICK_DIV),
                          .SCAN_DIV(SCAN_DIV), .LZ_BLANK(1)) dut_lz (
    .clk_in(clk_in), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .sel_an(sel_an), .num(num1), .an_scan(an_scan1),
    .bcd_all(bcd_all1), .wrap(wrap1));

  always #5 clk_in = ~clk_in;

  function automatic int pow10(input int n);
    int r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r = '0;
    for (int k = 0; k < ND; k++) r[4*k +: 4] = 4'((v / pow10(k)) % 10);
    return r;
  endfunction

  function automatic logic [3:0] exp_num();
    return 4'((m_val / pow10(m_idx)) % 10);
  endfunction

  function automatic logic [3:0] exp_an(input bit lz);
    int a = int'(sel_an) + 1;
    bit blank = (m_idx > 0);
    for (int k = m_idx; k < a; k++)
      if (((m_val / pow10(k)) % 10) != 0) blank = 1'b0;
    if (lz && blank) return 4'b1111;
    return ~(4'b0001 << m_idx);
  endfunction

  // Advance one clock edge; model consumes the inputs seen at that edge.
  task automatic tick_clk();
    int a, md, nib;
    bit t;
    @(posedge clk_in);
    if (!rst) begin
      m_val = 0; m_tc = 1; m_sc = 1; m_idx = 0; m_wrap = 1'b0;
    end else begin
      a  = int'(sel_an) + 1;
      md = pow10(a);
      t  = en && (m_tc == TICK_DIV);
      if (load) m_tc = 1;
      else if (en) m_tc = t ? 1 : m_tc + 1;
      if (load) begin
        m_val = 0;
        for (int k = 0; k < a; k++) begin
          nib = int'(load_val[4*k +: 4]);
          m_val += ((nib <= 9) ? nib : 0) * pow10(k);
        end
        m_wrap = 1'b0;
      end else if (t && up_dn) begin
        m_wrap = ((m_val % md) == md - 1);
        m_val  = (m_val % md + 1) % md;
      end else if (t) begin
        m_wrap = ((m_val % md) == 0);
        m_val  = (m_val % md + md - 1) % md;
      end else begin
        m_val  = m_val % md;
        m_wrap = 1'b0;
      end
      if (m_idx > a - 1) m_idx = 0;
      else if (m_sc == SCAN_DIV) m_idx = (m_idx >= a - 1) ? 0 : m_idx + 1;
      m_sc = (m_sc == SCAN_DIV) ? 1 : m_sc + 1;
    end
    #1;
  endtask

  task automatic test_reset();
    logic [3:0] seq [4];
    seq[0] = 4'b1101; seq[1] = 4'b1011; seq[2] = 4'b0111; seq[3] = 4'b1110;
    rst = 1'b0; en = 1'b0; load = 1'b0; sel_an = 2'd3; up_dn = 1'b1;
    tick_clk(); tick_clk();
    checks++;
    if (bcd_all !== 16'h0000) begin errors++; $display("FAIL reset_bcd: got %h want 0000", bcd_all); end
    checks++;
    if (wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap: got %b want 0", wrap); end
    checks++;
    if (an_scan !== 4'b1110 || num !== 4'd0) begin
      errors++; $display("FAIL reset_scan: an=%b num=%0d want 1110/0", an_scan, num);
    end
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick_clk();
      checks++;
      if (an_scan !== seq[i] || an_scan !== exp_an(1'b0)) begin
        errors++; $display("FAIL reset_scan_seq[%0d]: got %b want %b", i, an_scan, seq[i]);
      end
      checks++;
      if (bcd_all !== 16'h0000 || wrap !== 1'b0) begin
        errors++; $display("FAIL reset_hold[%0d]: bcd=%h wrap=%b want 0000/0", i, bcd_all, wrap);
      end
    end
  endtask

  task automatic test_wrap_up();
    int nwrap = 0;
    sel_an = 2'd3; up_dn = 1'b1; en = 1'b1; load = 1'b1; load_val = 16'h9998;
    tick_clk();
    load = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick_clk();
      if (wrap) nwrap++;
      checks++;
      if (bcd_all !== to_bcd(m_val) || wrap !== m_wrap) begin
        errors++; $display("FAIL wrap_up[%0d]: bcd=%h wrap=%b want %h/%b", i, bcd_all, wrap, to_bcd(m_val), m_wrap);
      end
    end
    checks++;
    if (nwrap != 1 || bcd_all !== 16'h0001) begin
      errors++; $display("FAIL wrap_up_end: wraps=%0d bcd=%h want 1/0001", nwrap, bcd_all);
    end
    en = 1'b0;
  endtask

  task automatic test_wrap_down();
    sel_an = 2'd1; up_dn = 1'b0; en = 1'b1; load = 1'b1; load_val = 16'h0000;
    tick_clk();
    load = 1'b0;
    tick_clk(); tick_clk();
    checks++;
    if (bcd_all !== 16'h0099 || wrap !== 1'b1) begin
      errors++; $display("FAIL wrap_down: bcd=%h wrap=%b want 0099/1", bcd_all, wrap);
    end
    for (int i = 0; i < 4; i++) begin
      tick_clk();
      checks++;
      if ((an_scan !== 4'b1110 && an_scan !== 4'b1101) || an_scan !== exp_an(1'b0)) begin
        errors++; $display("FAIL two_digit_scan[%0d]: got %b want %b", i, an_scan, exp_an(1'b0));
      end
    end
    en = 1'b0;
  endtask

  task automatic test_load_priority();
    int guard = 0;
    sel_an = 2'd3; up_dn = 1'b1; en = 1'b1;
    while (m_tc != TICK_DIV && guard < 8) begin tick_clk(); guard++; end
    checks++;
    if (m_tc != TICK_DIV) begin errors++; $display("FAIL load_prio_setup: timeout got %0d want %0d", m_tc, TICK_DIV); end
    load = 1'b1; load_val = 16'h12A4;
    tick_clk();
    load = 1'b0;
    checks++;
    if (bcd_all !== 16'h1204 || wrap !== 1'b0) begin
      errors++; $display("FAIL load_prio: bcd=%h wrap=%b want 1204/0", bcd_all, wrap);
    end
    tick_clk();
    checks++;
    if (bcd_all !== 16'h1204) begin errors++; $display("FAIL load_tick_restart1: got %h want 1204", bcd_all); end
    tick_clk();
    checks++;
    if (bcd_all !== 16'h1205) begin errors++; $display("FAIL load_tick_restart2: got %h want 1205", bcd_all); end
    en = 1'b0;
  endtask

  task automatic test_back_to_back();
    sel_an = 2'd3; en = 1'b0; load = 1'b1; load_val = 16'h3141;
    tick_clk();
    load_val = 16'h2718;
    tick_clk();
    load = 1'b0;
    checks++;
    if (bcd_all !== 16'h2718 || bcd_all !== to_bcd(m_val)) begin
      errors++; $display("FAIL back_to_back_load: got %h want 2718", bcd_all);
    end
  endtask

  task automatic test_shrink();
    int guard = 0;
    sel_an = 2'd3; en = 1'b0; load = 1'b1; load_val = 16'h4567;
    tick_clk();
    load = 1'b0;
    while (m_idx != 3 && guard < 8) begin tick_clk(); guard++; end
    checks++;
    if (an_scan !== 4'b0111 || num !== 4'd4) begin
      errors++; $display("FAIL shrink_setup: an=%b num=%0d want 0111/4", an_scan, num);
    end
    sel_an = 2'd0;
    tick_clk();
    checks++;
    if (an_scan !== 4'b1110 || bcd_all !== 16'h0007 || num !== 4'd7) begin
      errors++; $display("FAIL shrink: an=%b bcd=%h num=%0d want 1110/0007/7", an_scan, bcd_all, num);
    end
    en = 1'b1; up_dn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick_clk();
      checks++;
      if (bcd_all !== to_bcd(m_val) || wrap !== m_wrap || an_scan !== 4'b1110) begin
        errors++; $display("FAIL shrink_mod10[%0d]: bcd=%h wrap=%b an=%b want %h/%b/1110",
                           i, bcd_all, wrap, an_scan, to_bcd(m_val), m_wrap);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_lz_blank();
    int guard = 0;
    logic [3:0] an_e [4];
    logic [3:0] num_e [4];
    an_e[0] = 4'b1110; an_e[1] = 4'b1101; an_e[2] = 4'b1111; an_e[3] = 4'b1111;
    num_e[0] = 4'd2; num_e[1] = 4'd4; num_e[2] = 4'd0; num_e[3] = 4'd0;
    sel_an = 2'd3; en = 1'b0; load = 1'b1; load_val = 16'h0042;
    tick_clk();
    load = 1'b0;
    while (m_idx != 0 && guard < 8) begin tick_clk(); guard++; end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (an_scan1 !== an_e[i] || num1 !== num_e[i]) begin
        errors++; $display("FAIL lz_blank[%0d]: an=%b num=%0d want %b/%0d", i, an_scan1, num1, an_e[i], num_e[i]);
      end
      tick_clk();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) != 0);
      load = ($urandom_range(0, 15) == 0);
      load_val = 16'($urandom);
      if ($urandom_range(0, 3) == 0) load_val = to_bcd(($urandom_range(0, 1) != 0) ? 9999 : 0);
      if ($urandom_range(0, 31) == 0) sel_an = 2'($urandom);
      if ($urandom_range(0, 63) == 0) up_dn = ~up_dn;
      en = ($urandom_range(0, 7) != 0);
      tick_clk();
      checks++;
      if (bcd_all !== to_bcd(m_val) || wrap !== m_wrap || num !== exp_num() || an_scan !== exp_an(1'b0)) begin
        errors++;
        $display("FAIL random[%0d]: bcd=%h wrap=%b num=%0d an=%b want %h/%b/%0d/%b", i,
                 bcd_all, wrap, num, an_scan, to_bcd(m_val), m_wrap, exp_num(), exp_an(1'b0));
      end
      checks++;
      if (bcd_all1 !== to_bcd(m_val) || wrap1 !== m_wrap || num1 !== exp_num() || an_scan1 !== exp_an(1'b1)) begin
        errors++;
        $display("FAIL random_lz[%0d]: bcd=%h wrap=%b num=%0d an=%b want %h/%b/%0d/%b", i,
                 bcd_all1, wrap1, num1, an_scan1, to_bcd(m_val), m_wrap, exp_num(), exp_an(1'b1));
      end
    end
  endtask

  initial begin
    test_reset();
    test_wrap_up();
    test_wrap_down();
    test_load_priority();
    test_back_to_back();
    test_shrink();
    test_lz_blank();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
